// File: rtl/vcve2_wb_stage_if.sv
// -----------------------------------------------------------------------------
// vcve2_wb_stage_if
//   Vector beat bus and VRF write bus of the writeback stage.
//
//   Beat side (producer -> writeback stage):
//     vbeat_valid, vbeat_ready, vbeat_is_mem, vbeat_wdata_id, vbeat_wdata_lsu,
//     vbeat_last, vbeat_waddr (vector destination, sampled on the first beat)
//   VRF side (writeback stage -> register file):
//     vrf_we, vrf_ready, vrf_waddr, vrf_wdata, vrf_wbe
//
//   modport slave  : the writeback stage
//   modport master : the environment (ID/LSU beat producer and the VRF port)
// -----------------------------------------------------------------------------
interface vcve2_wb_stage_if #(
    parameter int ELEN = 32,
    parameter int VLEN = 128
);
    logic              vbeat_valid;
    logic              vbeat_ready;
    logic              vbeat_is_mem;
    logic [ELEN-1:0]   vbeat_wdata_id;
    logic [ELEN-1:0]   vbeat_wdata_lsu;
    logic              vbeat_last;
    logic [4:0]        vbeat_waddr;

    logic              vrf_we;
    logic              vrf_ready;
    logic [4:0]        vrf_waddr;
    logic [VLEN-1:0]   vrf_wdata;
    logic [VLEN/8-1:0] vrf_wbe;

    modport slave (
        input  vbeat_valid, vbeat_is_mem, vbeat_wdata_id, vbeat_wdata_lsu,
               vbeat_last, vbeat_waddr, vrf_ready,
        output vbeat_ready, vrf_we, vrf_waddr, vrf_wdata, vrf_wbe
    );

    modport master (
        output vbeat_valid, vbeat_is_mem, vbeat_wdata_id, vbeat_wdata_lsu,
               vbeat_last, vbeat_waddr, vrf_ready,
        input  vbeat_ready, vrf_we, vrf_waddr, vrf_wdata, vrf_wbe
    );
endinterface

// File: rtl/vcve2_wb_stage.sv
// -----------------------------------------------------------------------------
// vcve2_wb_stage
//   Registered writeback stage between ID/EX, LSU and the scalar/vector RFs.
//
//   Scalar path (latency 1): picks the lowest-index requesting source, registers
//   the RF write, flags multi-source conflicts and produces retire pulses.
//   Vector path: collects ELEN-wide beats into one VLEN-wide VRF write with a
//   byte-enable mask; valid/ready on the beat side, we/ready on the VRF side.
//
//   Ports:
//     clk_i, rst_i                 clock, asynchronous active-high reset
//     en_wb_i, instr_perf_count_i,
//     instr_is_compressed_i        retire qualification
//     lsu_resp_valid_i/err_i       LSU response (error suppresses retire)
//     src_we_i, src_wdata_i        per-source scalar write requests / data
//     rf_waddr_i                   scalar destination
//     rf_we_o/waddr_o/wdata_o      registered scalar RF write
//     src_conflict_o               more than one source requested
//     perf_instr_ret_o,
//     perf_instr_ret_compressed_o  retire pulses
//     vbus                         vector beat + VRF write bus (slave side)
//
//   Optional: define VCVE2_WB_FWD_EN to add the forwarding ports
//     fwd_valid_o, fwd_waddr_o, fwd_wdata_o, vfwd_pending_o, vfwd_waddr_o.
// -----------------------------------------------------------------------------
module vcve2_wb_stage #(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 3,
    parameter int ELEN    = 32,
    parameter int VLEN    = 128
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    en_wb_i,
    input  logic                    instr_perf_count_i,
    input  logic                    instr_is_compressed_i,
    input  logic                    lsu_resp_valid_i,
    input  logic                    lsu_resp_err_i,

    input  logic [NUM_SRC-1:0]      src_we_i,
    input  logic [NUM_SRC*XLEN-1:0] src_wdata_i,
    input  logic [4:0]              rf_waddr_i,

    output logic                    rf_we_o,
    output logic [4:0]              rf_waddr_o,
    output logic [XLEN-1:0]         rf_wdata_o,
    output logic                    src_conflict_o,
    output logic                    perf_instr_ret_o,
    output logic                    perf_instr_ret_compressed_o,

    vcve2_wb_stage_if.slave         vbus
`ifdef VCVE2_WB_FWD_EN
    ,
    output logic                    fwd_valid_o,
    output logic [4:0]              fwd_waddr_o,
    output logic [XLEN-1:0]         fwd_wdata_o,
    output logic                    vfwd_pending_o,
    output logic [4:0]              vfwd_waddr_o
`endif
);

    localparam int NBEATS = VLEN / ELEN;
    localparam int BPB    = ELEN / 8;
    localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    // ------------------------------------------------------------------
    // Scalar path
    // ------------------------------------------------------------------
    logic [XLEN-1:0] sel_wdata;
    logic            multi_we;
    logic            retire;

    always_comb begin
        // NOTE: default first, so no path through the loop leaves sel_wdata
        // unassigned and a latch is never inferred.
        sel_wdata = '0;
        // Walk from the highest index down so the lowest requester wins.
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (src_we_i[k]) sel_wdata = src_wdata_i[k*XLEN +: XLEN];
        end
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_we = |(src_we_i & (src_we_i - NUM_SRC'(1)));
    assign retire   = instr_perf_count_i & en_wb_i & ~(lsu_resp_valid_i & lsu_resp_err_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rf_we_o                     <= 1'b0;
            rf_waddr_o                  <= '0;
            rf_wdata_o                  <= '0;
            src_conflict_o              <= 1'b0;
            perf_instr_ret_o            <= 1'b0;
            perf_instr_ret_compressed_o <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments: every register here samples the
            // pre-edge values, independent of statement order.
            rf_we_o                     <= |src_we_i;
            rf_waddr_o                  <= rf_waddr_i;
            rf_wdata_o                  <= sel_wdata;
            src_conflict_o              <= multi_we;
            perf_instr_ret_o            <= retire;
            perf_instr_ret_compressed_o <= retire & instr_is_compressed_i;
        end
    end

    conflict_flagged: assert property (
        @(posedge clk_i) disable iff (rst_i) multi_we |=> src_conflict_o
    );

    // ------------------------------------------------------------------
    // Vector path
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        V_IDLE,
        V_COLLECT,
        V_WRITE
    } vstate_e;

    vstate_e           state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [VLEN-1:0]   data_q;
    logic [VLEN/8-1:0] wbe_q;
    logic [4:0]        waddr_q;
    logic              vrf_we_q;
    logic              ready_q;

    logic              accept;
    logic              beat_last;
    logic [ELEN-1:0]   beat_data;

    assign accept    = ready_q & vbus.vbeat_valid;
    assign beat_data = vbus.vbeat_is_mem ? vbus.vbeat_wdata_lsu : vbus.vbeat_wdata_id;
    // A beat landing in the top slot closes the register even without vbeat_last.
    assign beat_last = vbus.vbeat_last | (cnt_q == CNT_W'(NBEATS - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= V_IDLE;
            cnt_q    <= '0;
            // NOTE: the beat buffer is a plain register (not a RAM macro), so
            // resetting it is cheap and keeps the VRF data bus deterministic.
            data_q   <= '0;
            wbe_q    <= '0;
            waddr_q  <= '0;
            vrf_we_q <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            case (state_q)
                V_IDLE, V_COLLECT: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        data_q[int'(cnt_q)*ELEN +: ELEN] <= beat_data;
                        wbe_q[int'(cnt_q)*BPB +: BPB]    <= '1;
                        if (state_q == V_IDLE) waddr_q <= vbus.vbeat_waddr;
                        if (beat_last) begin
                            // cnt is held here and cleared on leaving WRITE.
                            state_q  <= V_WRITE;
                            vrf_we_q <= 1'b1;
                            ready_q  <= 1'b0;
                        end else begin
                            state_q  <= V_COLLECT;
                            cnt_q    <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                V_WRITE: begin
                    if (vbus.vrf_ready) begin
                        state_q  <= V_IDLE;
                        cnt_q    <= '0;
                        wbe_q    <= '0;
                        vrf_we_q <= 1'b0;
                        ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= V_IDLE;
                    cnt_q    <= '0;
                    wbe_q    <= '0;
                    vrf_we_q <= 1'b0;
                    ready_q  <= 1'b0;
                end
            endcase
        end
    end

    assign vbus.vbeat_ready = ready_q;
    assign vbus.vrf_we      = vrf_we_q;
    assign vbus.vrf_waddr   = waddr_q;
    assign vbus.vrf_wdata   = data_q;
    assign vbus.vrf_wbe     = wbe_q;

`ifdef VCVE2_WB_FWD_EN
    assign fwd_valid_o    = rf_we_o;
    assign fwd_waddr_o    = rf_waddr_o;
    assign fwd_wdata_o    = rf_wdata_o;
    assign vfwd_pending_o = (state_q != V_IDLE);
    assign vfwd_waddr_o   = waddr_q;
`endif

endmodule

// File: tb/tb_vcve2_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_vcve2_wb_stage
//   Self-checking bench for vcve2_wb_stage: table of scalar vectors plus
//   hand-written vector-path sequences (full, partial with backpressure,
//   implicit last, reset mid-collect).
// -----------------------------------------------------------------------------
module tb_vcve2_wb_stage;

    localparam int XLEN    = 32;
    localparam int NUM_SRC = 3;
    localparam int ELEN    = 32;
    localparam int VLEN    = 128;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                    en_wb, perf_cnt, is_comp, lsu_valid, lsu_err;
    logic [NUM_SRC-1:0]      src_we;
    logic [NUM_SRC*XLEN-1:0] src_wdata;
    logic [4:0]              rf_waddr_in;
    logic                    rf_we, src_conflict, ret, ret_c;
    logic [4:0]              rf_waddr;
    logic [XLEN-1:0]         rf_wdata;
`ifdef VCVE2_WB_FWD_EN
    logic                    fwd_valid, vfwd_pending;
    logic [4:0]              fwd_waddr, vfwd_waddr;
    logic [XLEN-1:0]         fwd_wdata;
`endif

    vcve2_wb_stage_if #(.ELEN(ELEN), .VLEN(VLEN)) vif ();

    vcve2_wb_stage #(
        .XLEN(XLEN), .NUM_SRC(NUM_SRC), .ELEN(ELEN), .VLEN(VLEN)
    ) dut (
        .clk_i                       (clk),
        .rst_i                       (rst),
        .en_wb_i                     (en_wb),
        .instr_perf_count_i          (perf_cnt),
        .instr_is_compressed_i       (is_comp),
        .lsu_resp_valid_i            (lsu_valid),
        .lsu_resp_err_i              (lsu_err),
        .src_we_i                    (src_we),
        .src_wdata_i                 (src_wdata),
        .rf_waddr_i                  (rf_waddr_in),
        .rf_we_o                     (rf_we),
        .rf_waddr_o                  (rf_waddr),
        .rf_wdata_o                  (rf_wdata),
        .src_conflict_o              (src_conflict),
        .perf_instr_ret_o            (ret),
        .perf_instr_ret_compressed_o (ret_c),
        .vbus                        (vif)
`ifdef VCVE2_WB_FWD_EN
        ,
        .fwd_valid_o                 (fwd_valid),
        .fwd_waddr_o                 (fwd_waddr),
        .fwd_wdata_o                 (fwd_wdata),
        .vfwd_pending_o              (vfwd_pending),
        .vfwd_waddr_o                (vfwd_waddr)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  we;
        logic [31:0] d0, d1, d2;
        logic [4:0]  waddr;
        logic        en, perf, comp, lv, le;
        logic        e_we;
        logic [4:0]  e_waddr;
        logic [31:0] e_data;
        logic        e_conf, e_ret, e_retc;
    } svec_t;

    // Drive one beat at a negedge; return at the negedge after it was accepted.
    task automatic send_beat(input logic [31:0] d, input logic mem, input logic last,
                             input logic [4:0] wa);
        int waited = 0;
        vif.vbeat_valid     = 1'b1;
        vif.vbeat_is_mem    = mem;
        vif.vbeat_wdata_id  = mem ? ~d : d;
        vif.vbeat_wdata_lsu = mem ? d : ~d;
        vif.vbeat_last      = last;
        vif.vbeat_waddr     = wa;
        while (!vif.vbeat_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!vif.vbeat_ready) check("beat_ready_timeout", vif.vbeat_ready, 1);
        @(negedge clk);
        vif.vbeat_valid = 1'b0;
        vif.vbeat_last  = 1'b0;
    endtask

    task automatic check_write(input string tag, input logic [4:0] wa,
                               input logic [127:0] data, input logic [15:0] wbe);
        check({tag, "_we"},    vif.vrf_we, 1'b1);
        check({tag, "_waddr"}, vif.vrf_waddr, wa);
        check({tag, "_wdata"}, vif.vrf_wdata, data);
        check({tag, "_wbe"},   vif.vrf_wbe, wbe);
        check({tag, "_ready"}, vif.vbeat_ready, 1'b0);
    endtask

    svec_t svec[13];

    initial begin
        svec[0]  = '{3'b001, 32'h1234, 32'h5678, 32'h9ABC,  5, 0,0,0,0,0, 1,  5, 32'h1234, 0, 0, 0};
        svec[1]  = '{3'b011, 32'h1111, 32'h2222, 32'h3333,  7, 0,0,0,0,0, 1,  7, 32'h1111, 1, 0, 0};
        svec[2]  = '{3'b010, 32'h4444, 32'h5555, 32'h6666,  8, 0,0,0,0,0, 1,  8, 32'h5555, 0, 0, 0};
        svec[3]  = '{3'b100, 32'h7777, 32'h8888, 32'h9999, 31, 0,0,0,0,0, 1, 31, 32'h9999, 0, 0, 0};
        svec[4]  = '{3'b110, 32'hAAAA, 32'hBBBB, 32'hCCCC,  1, 0,0,0,0,0, 1,  1, 32'hBBBB, 1, 0, 0};
        svec[5]  = '{3'b111, 32'hDEAD, 32'hBEEF, 32'hF00D,  2, 0,0,0,0,0, 1,  2, 32'hDEAD, 1, 0, 0};
        svec[6]  = '{3'b000, 32'h0,    32'h0,    32'h0,     3, 0,0,0,0,0, 0,  3, 32'h0,    0, 0, 0};
        svec[7]  = '{3'b000, 32'h0,    32'h0,    32'h0,     3, 1,1,1,1,1, 0,  3, 32'h0,    0, 0, 0};
        svec[8]  = '{3'b000, 32'h0,    32'h0,    32'h0,     3, 1,1,1,1,0, 0,  3, 32'h0,    0, 1, 1};
        svec[9]  = '{3'b000, 32'h0,    32'h0,    32'h0,     3, 1,1,0,0,1, 0,  3, 32'h0,    0, 1, 0};
        svec[10] = '{3'b000, 32'h0,    32'h0,    32'h0,     3, 0,1,1,0,0, 0,  3, 32'h0,    0, 0, 0};
        svec[11] = '{3'b000, 32'h0,    32'h0,    32'h0,     3, 1,0,1,0,0, 0,  3, 32'h0,    0, 0, 0};
        svec[12] = '{3'b001, 32'h600D, 32'h1,    32'h2,     0, 1,1,1,1,0, 1,  0, 32'h600D, 0, 1, 1};

        rst = 1'b1;
        {en_wb, perf_cnt, is_comp, lsu_valid, lsu_err} = '0;
        src_we = '0; src_wdata = '0; rf_waddr_in = '0;
        vif.vbeat_valid = 1'b0; vif.vbeat_is_mem = 1'b0; vif.vbeat_last = 1'b0;
        vif.vbeat_wdata_id = '0; vif.vbeat_wdata_lsu = '0; vif.vbeat_waddr = '0;
        vif.vrf_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_rf_we",    rf_we, 0);
        check("rst_rf_waddr", rf_waddr, 0);
        check("rst_rf_wdata", rf_wdata, 0);
        check("rst_conflict", src_conflict, 0);
        check("rst_ret",      {ret, ret_c}, 0);
        check("rst_vrf_we",   vif.vrf_we, 0);
        check("rst_vrf_wbe",  vif.vrf_wbe, 0);
        check("rst_vrf_data", vif.vrf_wdata, 0);
        check("rst_ready",    vif.vbeat_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", vif.vbeat_ready, 1);

        // Scalar path: each vector is driven at a negedge and checked one edge later.
        for (int i = 0; i < 13; i++) begin
            src_we      = svec[i].we;
            src_wdata   = {svec[i].d2, svec[i].d1, svec[i].d0};
            rf_waddr_in = svec[i].waddr;
            {en_wb, perf_cnt, is_comp, lsu_valid, lsu_err} =
                {svec[i].en, svec[i].perf, svec[i].comp, svec[i].lv, svec[i].le};
            @(negedge clk);
            check($sformatf("s%0d_we", i),       rf_we, svec[i].e_we);
            check($sformatf("s%0d_waddr", i),    rf_waddr, svec[i].e_waddr);
            if (svec[i].e_we) check($sformatf("s%0d_wdata", i), rf_wdata, svec[i].e_data);
            check($sformatf("s%0d_conflict", i), src_conflict, svec[i].e_conf);
            check($sformatf("s%0d_ret", i),      ret, svec[i].e_ret);
            check($sformatf("s%0d_ret_c", i),    ret_c, svec[i].e_retc);
`ifdef VCVE2_WB_FWD_EN
            check($sformatf("s%0d_fwd_valid", i), fwd_valid, svec[i].e_we);
            check($sformatf("s%0d_fwd_waddr", i), fwd_waddr, svec[i].e_waddr);
            if (svec[i].e_we) check($sformatf("s%0d_fwd_wdata", i), fwd_wdata, svec[i].e_data);
`endif
        end
        src_we = '0;
        {en_wb, perf_cnt, is_comp, lsu_valid, lsu_err} = '0;
        @(negedge clk);
        check("ret_one_cycle", {ret, ret_c}, 2'b00);

        // Full register, vrf_ready held high throughout (ignored until WRITE).
        vif.vrf_ready = 1'b1;
        send_beat(32'hA0, 0, 0, 10);
`ifdef VCVE2_WB_FWD_EN
        check("vfwd_pending", vfwd_pending, 1);
        check("vfwd_waddr",   vfwd_waddr, 10);
`endif
        send_beat(32'hA1, 1, 0, 20);
        send_beat(32'hA2, 0, 0, 20);
        send_beat(32'hA3, 1, 1, 20);
        check_write("full", 10, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 16'hFFFF);
        @(negedge clk);
        check("full_done_we",    vif.vrf_we, 0);
        check("full_done_ready", vif.vbeat_ready, 1);

        // Partial register with VRF backpressure; upper slots keep old data.
        vif.vrf_ready = 1'b0;
        send_beat(32'hB0, 0, 0, 9);
        send_beat(32'hB1, 1, 1, 12);
        for (int c = 0; c < 3; c++) begin
            check_write($sformatf("part_c%0d", c), 9,
                        {32'hA3, 32'hA2, 32'hB1, 32'hB0}, 16'h00FF);
            @(negedge clk);
        end
        check("part_hold_we", vif.vrf_we, 1);
        vif.vrf_ready = 1'b1;
        @(negedge clk);
        check("part_done_we",    vif.vrf_we, 0);
        check("part_done_ready", vif.vbeat_ready, 1);
        check("part_done_wbe",   vif.vrf_wbe, 0);

        // Implicit last after NBEATS beats; the next beat restarts at slot 0.
        send_beat(32'hC0, 0, 0, 4);
        send_beat(32'hC1, 0, 0, 0);
        send_beat(32'hC2, 1, 0, 0);
        send_beat(32'hC3, 0, 0, 0);
        check_write("impl", 4, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 16'hFFFF);
        @(negedge clk);
        check("impl_done_we", vif.vrf_we, 0);
        send_beat(32'hD0, 1, 1, 6);
        check_write("impl_next", 6, {32'hC3, 32'hC2, 32'hC1, 32'hD0}, 16'h000F);
        @(negedge clk);
        check("impl_next_done_we", vif.vrf_we, 0);

        // Reset mid-collect discards the partial register.
        vif.vrf_ready = 1'b0;
        send_beat(32'hE0, 0, 0, 11);
        send_beat(32'hE1, 0, 0, 11);
        rst = 1'b1;
        #1;
        check("midrst_we",    vif.vrf_we, 0);
        check("midrst_ready", vif.vbeat_ready, 0);
        check("midrst_wbe",   vif.vrf_wbe, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("postrst_we_c%0d", c), vif.vrf_we, 0);
        end
        vif.vrf_ready = 1'b1;
        send_beat(32'hF0, 0, 0, 13);
        send_beat(32'hF1, 1, 0, 13);
        send_beat(32'hF2, 0, 0, 13);
        send_beat(32'hF3, 1, 1, 13);
        check_write("postrst", 13, {32'hF3, 32'hF2, 32'hF1, 32'hF0}, 16'hFFFF);
        @(negedge clk);
        check("postrst_done_we", vif.vrf_we, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
